// File: rtl/alt_vipcti131_common_wrap_counter.sv
// Wrapping up-counter: wraps to 0 on enable once value >= terminal.
// sclr presents a cleared value this cycle; zero forces the next value to 0.
module alt_vipcti131_common_wrap_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr,
  input  logic             zero,
  input  logic             en,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] value,
  output logic             at_end,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;

  // sclr clears the state seen this cycle, so an enable in the same cycle counts from 0
  assign value  = sclr ? '0 : count_q;
  assign at_end = (value >= terminal);
  assign wrap   = en & at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (zero) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= at_end ? '0 : value + WIDTH'(1);
    end else begin
      count_q <= value;
    end
  end

endmodule

// File: rtl/alt_vipcti131_common_sample_position_counter.sv
// Groups colour-plane cycles into samples and tracks the sample's x/y position
// within a frame whose size is latched at frame start.
module alt_vipcti131_common_sample_position_counter #(
  parameter int NUMBER_OF_COLOUR_PLANES      = 3,
  parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2,
  parameter int WIDTH_BITS                   = 12,
  parameter int HEIGHT_BITS                  = 12
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    sclr,
  input  logic                                    count_cycle,
  input  logic                                    hd_sdn,
  input  logic [WIDTH_BITS-1:0]                   active_width,
  input  logic [HEIGHT_BITS-1:0]                  active_height,
  output logic                                    count_sample,
  output logic                                    start_of_sample,
  output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks,
  output logic [WIDTH_BITS-1:0]                   pixel_x,
  output logic [HEIGHT_BITS-1:0]                  line_y,
  output logic                                    end_of_line,
  output logic                                    end_of_frame
);

  localparam logic SINGLE_PLANE = (NUMBER_OF_COLOUR_PLANES == 1);
  localparam logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] PLANE_LAST =
    LOG2_NUMBER_OF_COLOUR_PLANES'(NUMBER_OF_COLOUR_PLANES - 1);

  // Last valid index for a programmed size, with a size of 0 behaving as 1
  function automatic logic [WIDTH_BITS-1:0] last_x(input logic [WIDTH_BITS-1:0] size);
    return (size == '0) ? '0 : size - WIDTH_BITS'(1);
  endfunction

  function automatic logic [HEIGHT_BITS-1:0] last_y(input logic [HEIGHT_BITS-1:0] size);
    return (size == '0) ? '0 : size - HEIGHT_BITS'(1);
  endfunction

  logic [WIDTH_BITS-1:0]  sw_q;
  logic [HEIGHT_BITS-1:0] sh_q;
  logic [WIDTH_BITS-1:0]  sw_cur;
  logic [HEIGHT_BITS-1:0] sh_cur;
  logic                   plane_at_end;
  logic                   plane_wrap;
  logic                   x_at_end;
  logic                   y_at_end;
  logic                   y_wrap;

  assign sw_cur = sclr ? active_width  : sw_q;
  assign sh_cur = sclr ? active_height : sh_q;

  alt_vipcti131_common_wrap_counter #(
    .WIDTH(LOG2_NUMBER_OF_COLOUR_PLANES)
  ) u_plane (
    .clk      (clk),
    .rst      (rst),
    .sclr     (sclr),
    .zero     (hd_sdn | SINGLE_PLANE),
    .en       (count_cycle),
    .terminal (PLANE_LAST),
    .value    (sample_ticks),
    .at_end   (plane_at_end),
    .wrap     (plane_wrap)
  );

  assign count_sample = count_cycle & (hd_sdn | SINGLE_PLANE | plane_at_end);

  alt_vipcti131_common_wrap_counter #(
    .WIDTH(WIDTH_BITS)
  ) u_x (
    .clk      (clk),
    .rst      (rst),
    .sclr     (sclr),
    .zero     (1'b0),
    .en       (count_sample),
    .terminal (last_x(sw_cur)),
    .value    (pixel_x),
    .at_end   (x_at_end),
    .wrap     (end_of_line)
  );

  alt_vipcti131_common_wrap_counter #(
    .WIDTH(HEIGHT_BITS)
  ) u_y (
    .clk      (clk),
    .rst      (rst),
    .sclr     (sclr),
    .zero     (1'b0),
    .en       (end_of_line),
    .terminal (last_y(sh_cur)),
    .value    (line_y),
    .at_end   (y_at_end),
    .wrap     (y_wrap)
  );

  assign end_of_frame    = y_wrap;
  assign start_of_sample = hd_sdn | (sample_ticks == '0);

  // Size inputs are only sampled at frame boundaries so mid-frame edits are deferred
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_q <= '0;
      sh_q <= '0;
    end else if (sclr | end_of_frame) begin
      sw_q <= active_width;
      sh_q <= active_height;
    end
  end

endmodule

// File: tb/tb_alt_vipcti131_common_sample_position_counter.sv
// Directed bench for the sample position counter (N=3 planes, 12-bit sizes).
module tb_alt_vipcti131_common_sample_position_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclr = 1'b0;
  logic        count_cycle = 1'b0;
  logic        hd_sdn = 1'b0;
  logic [11:0] active_width = '0;
  logic [11:0] active_height = '0;
  logic        count_sample;
  logic        start_of_sample;
  logic [1:0]  sample_ticks;
  logic [11:0] pixel_x;
  logic [11:0] line_y;
  logic        end_of_line;
  logic        end_of_frame;

  int compared = 0;
  int mismatched = 0;

  alt_vipcti131_common_sample_position_counter #(
    .NUMBER_OF_COLOUR_PLANES(3),
    .LOG2_NUMBER_OF_COLOUR_PLANES(2),
    .WIDTH_BITS(12),
    .HEIGHT_BITS(12)
  ) dut (
    .clk(clk), .rst(rst), .sclr(sclr), .count_cycle(count_cycle), .hd_sdn(hd_sdn),
    .active_width(active_width), .active_height(active_height),
    .count_sample(count_sample), .start_of_sample(start_of_sample),
    .sample_ticks(sample_ticks), .pixel_x(pixel_x), .line_y(line_y),
    .end_of_line(end_of_line), .end_of_frame(end_of_frame)
  );

  always #5 clk = ~clk;

  // Inputs are applied 1 ns after a rising edge; outputs are checked 2 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_restart(input logic hd, input int w, input int h);
    hd_sdn = hd; sclr = 1'b1; count_cycle = 1'b0;
    active_width = 12'(w); active_height = 12'(h);
    tick();
    sclr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; count_cycle = 1'b0; hd_sdn = 1'b0;
    #2;
    compared++;
    if ({count_sample, start_of_sample, sample_ticks, end_of_line, end_of_frame} !== 6'b010000) begin
      mismatched++;
      $display("FAIL reset_flags: got cs=%b sos=%b ticks=%0d eol=%b eof=%b, want 0 1 0 0 0",
               count_sample, start_of_sample, sample_ticks, end_of_line, end_of_frame);
    end
    compared++;
    if (pixel_x !== 12'd0 || line_y !== 12'd0) begin
      mismatched++;
      $display("FAIL reset_pos: got x=%0d y=%0d, want 0 0", pixel_x, line_y);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sd_frame();
    int errs;
    frame_restart(1'b0, 4, 2);
    count_cycle = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      #2;
      errs = 0;
      if (count_sample !== ((i % 3) == 0)) errs++;
      if (sample_ticks !== 2'((i - 1) % 3)) errs++;
      if (pixel_x !== 12'(((i - 1) / 3) % 4)) errs++;
      if (line_y !== 12'((i - 1) / 12)) errs++;
      if (end_of_line !== (i == 12 || i == 24)) errs++;
      if (end_of_frame !== (i == 24)) errs++;
      compared++;
      if (errs != 0) begin
        mismatched++;
        $display("FAIL sd_frame cycle %0d: got cs=%b ticks=%0d x=%0d y=%0d eol=%b eof=%b",
                 i, count_sample, sample_ticks, pixel_x, line_y, end_of_line, end_of_frame);
      end
      @(posedge clk); #1;
    end
    count_cycle = 1'b0;
    #2;
    compared++;
    if (sample_ticks !== 2'd0 || pixel_x !== 12'd0 || line_y !== 12'd0) begin
      mismatched++;
      $display("FAIL sd_frame_wrap: got ticks=%0d x=%0d y=%0d, want 0 0 0", sample_ticks, pixel_x, line_y);
    end
    tick();
  endtask

  task automatic test_hd();
    int errs;
    frame_restart(1'b1, 3, 3);
    count_cycle = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      #2;
      errs = 0;
      if (count_sample !== 1'b1 || start_of_sample !== 1'b1 || sample_ticks !== 2'd0) errs++;
      if (pixel_x !== 12'((i - 1) % 3) || line_y !== 12'((i - 1) / 3)) errs++;
      if (end_of_line !== ((i % 3) == 0) || end_of_frame !== (i == 9)) errs++;
      compared++;
      if (errs != 0) begin
        mismatched++;
        $display("FAIL hd_frame cycle %0d: got cs=%b sos=%b ticks=%0d x=%0d y=%0d eol=%b eof=%b",
                 i, count_sample, start_of_sample, sample_ticks, pixel_x, line_y, end_of_line, end_of_frame);
      end
      @(posedge clk); #1;
    end
    count_cycle = 1'b0;
  endtask

  task automatic test_width_change();
    logic [1:0] got;
    frame_restart(1'b1, 4, 2);
    count_cycle = 1'b1;
    // Current frame keeps W=4 (8 samples); the next one uses W=2 (4 samples).
    for (int i = 1; i <= 12; i++) begin
      if (i == 3) active_width = 12'd2;
      #2;
      got = {end_of_line, end_of_frame};
      compared++;
      if (i <= 8) begin
        if (got !== {(i % 4) == 0, i == 8}) begin
          mismatched++;
          $display("FAIL width_change old cycle %0d: got eol,eof=%b", i, got);
        end
      end else begin
        if (got !== {(i % 2) == 0, i == 12}) begin
          mismatched++;
          $display("FAIL width_change new cycle %0d: got eol,eof=%b", i, got);
        end
      end
      @(posedge clk); #1;
    end
    count_cycle = 1'b0;
  endtask

  task automatic test_sclr_count();
    frame_restart(1'b0, 4, 3);
    count_cycle = 1'b1;
    repeat (18) tick();
    count_cycle = 1'b0;
    #2;
    compared++;
    if (pixel_x !== 12'd2 || line_y !== 12'd1 || sample_ticks !== 2'd0) begin
      mismatched++;
      $display("FAIL sclr_setup: got x=%0d y=%0d ticks=%0d, want 2 1 0", pixel_x, line_y, sample_ticks);
    end
    tick();
    sclr = 1'b1; count_cycle = 1'b1; active_width = 12'd5; active_height = 12'd6;
    #2;
    compared++;
    if (pixel_x !== 12'd0 || line_y !== 12'd0 || sample_ticks !== 2'd0 || count_sample !== 1'b0) begin
      mismatched++;
      $display("FAIL sclr_same_cycle: got x=%0d y=%0d ticks=%0d cs=%b, want 0 0 0 0",
               pixel_x, line_y, sample_ticks, count_sample);
    end
    tick();
    sclr = 1'b0; count_cycle = 1'b0; active_width = 12'd2; active_height = 12'd1;
    #2;
    compared++;
    if (sample_ticks !== 2'd1 || pixel_x !== 12'd0 || line_y !== 12'd0) begin
      mismatched++;
      $display("FAIL sclr_next: got ticks=%0d x=%0d y=%0d, want 1 0 0", sample_ticks, pixel_x, line_y);
    end
    tick();
    // Shadow width 5 from the sclr cycle: the 5th sample ends the line.
    count_cycle = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      #2;
      compared++;
      if (end_of_line !== (i == 14) || end_of_frame !== 1'b0) begin
        mismatched++;
        $display("FAIL sclr_shadow cycle %0d: got eol=%b eof=%b", i, end_of_line, end_of_frame);
      end
      @(posedge clk); #1;
    end
    count_cycle = 1'b0;
    #2;
    compared++;
    if (line_y !== 12'd1 || pixel_x !== 12'd0) begin
      mismatched++;
      $display("FAIL sclr_shadow_pos: got x=%0d y=%0d, want 0 1", pixel_x, line_y);
    end
    tick();
  endtask

  task automatic test_zero_size();
    frame_restart(1'b1, 0, 0);
    count_cycle = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #2;
      compared++;
      if (end_of_line !== 1'b1 || end_of_frame !== 1'b1 || pixel_x !== 12'd0 || line_y !== 12'd0) begin
        mismatched++;
        $display("FAIL zero_size cycle %0d: got eol=%b eof=%b x=%0d y=%0d, want 1 1 0 0",
                 i, end_of_line, end_of_frame, pixel_x, line_y);
      end
      @(posedge clk); #1;
    end
    count_cycle = 1'b0;
  endtask

  task automatic test_reset_mid();
    frame_restart(1'b0, 8, 5);
    count_cycle = 1'b1;
    repeat (89) tick();
    count_cycle = 1'b0;
    #2;
    compared++;
    if (pixel_x !== 12'd5 || line_y !== 12'd3 || sample_ticks !== 2'd2) begin
      mismatched++;
      $display("FAIL reset_mid_setup: got x=%0d y=%0d ticks=%0d, want 5 3 2", pixel_x, line_y, sample_ticks);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (pixel_x !== 12'd0 || line_y !== 12'd0 || sample_ticks !== 2'd0 || start_of_sample !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid_async: got x=%0d y=%0d ticks=%0d sos=%b, want 0 0 0 1",
               pixel_x, line_y, sample_ticks, start_of_sample);
    end
    tick();
    rst = 1'b0;
    count_cycle = 1'b1;
    tick();
    count_cycle = 1'b0;
    #2;
    compared++;
    if (sample_ticks !== 2'd1 || pixel_x !== 12'd0) begin
      mismatched++;
      $display("FAIL reset_mid_resume: got ticks=%0d x=%0d, want 1 0", sample_ticks, pixel_x);
    end
    tick();
  endtask

  task automatic test_hd_toggle();
    frame_restart(1'b0, 8, 5);
    count_cycle = 1'b1;
    repeat (4) tick();
    hd_sdn = 1'b1; count_cycle = 1'b0;
    #2;
    compared++;
    if (sample_ticks !== 2'd1 || pixel_x !== 12'd1 || count_sample !== 1'b0) begin
      mismatched++;
      $display("FAIL hd_toggle_setup: got ticks=%0d x=%0d cs=%b, want 1 1 0", sample_ticks, pixel_x, count_sample);
    end
    tick();
    #2;
    compared++;
    if (sample_ticks !== 2'd0 || pixel_x !== 12'd1 || start_of_sample !== 1'b1) begin
      mismatched++;
      $display("FAIL hd_toggle_drop: got ticks=%0d x=%0d sos=%b, want 0 1 1", sample_ticks, pixel_x, start_of_sample);
    end
    tick();
    hd_sdn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sd_frame();
    test_hd();
    test_width_change();
    test_sclr_count();
    test_zero_size();
    test_reset_mid();
    test_hd_toggle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alt_vipcti131_common_sample_position_counter.md
# alt_vipcti131_common_sample_position_counter

Parametrised successor to the clocked-video sample counter. It groups colour-plane cycles into samples (sequential planes in SD mode, one sample per cycle in HD mode) and tracks the sample's horizontal and vertical position within a frame of run-time-programmable active size. It sits in the clocked video input/output datapath next to the sync decoder and drives plane select, line-end and frame-end control.

## Interface
Parameters:
- NUMBER_OF_COLOUR_PLANES, 3: colour planes per sample in sequential (SD) mode, 1..4
- LOG2_NUMBER_OF_COLOUR_PLANES, 2: width of sample_ticks, at least 1
- WIDTH_BITS, 12: width of active_width and pixel_x
- HEIGHT_BITS, 12: width of active_height and line_y

Ports:
- clk  in  1  clock; all state is updated on the rising edge
- rst  in  1  reset, asynchronous and active-high
- sclr  in  1  synchronous frame restart
- count_cycle  in  1  one valid plane cycle (SD) or one sample (HD)
- hd_sdn  in  1  1 = HD (one sample per cycle), 0 = SD (planes in sequence)
- active_width  in  WIDTH_BITS  samples per line; 0 is treated as 1
- active_height  in  HEIGHT_BITS  lines per frame; 0 is treated as 1
- count_sample  out  1  the current cycle completes a sample
- start_of_sample  out  1  the current cycle is plane 0 of a sample
- sample_ticks  out  LOG2_NUMBER_OF_COLOUR_PLANES  current plane index
- pixel_x  out  WIDTH_BITS  sample index within the line
- line_y  out  HEIGHT_BITS  line index within the frame
- end_of_line  out  1  count_sample on the last sample of the line
- end_of_frame  out  1  end_of_line on the last line of the frame

## Operation
- State: plane counter P, x counter X, y counter Y, and shadow registers SW and SH.
- Effective size: W = max(SW,1) and H = max(SH,1).
- SW and SH load active_width and active_height on sclr and on any edge where end_of_frame=1. Changing the size inputs mid-frame has no effect until the next frame.
- Plane counter:
  - In HD mode, or when NUMBER_OF_COLOUR_PLANES==1, P is forced to 0 at every edge.
  - Otherwise, on count_cycle, P wraps NUMBER_OF_COLOUR_PLANES-1 → 0, else P+1.
- count_sample = count_cycle & (hd_sdn | NUMBER_OF_COLOUR_PLANES==1 | P==NUMBER_OF_COLOUR_PLANES-1).
- start_of_sample = hd_sdn | (P==0). sample_ticks = P.
- On count_sample:
  - If X==W-1: X→0, and Y wraps H-1 → 0 else Y+1.
  - Otherwise X→X+1.
- end_of_line = count_sample & (X==W-1). end_of_frame = end_of_line & (Y==H-1).
- All outputs are combinational from state and current inputs; no output register.
- sclr has priority over normal counting:
  - State is treated as P=X=Y=0, with SW and SH taken from the inputs.
  - The count_cycle of the same cycle is applied to that cleared state.
  - Outputs in the sclr cycle are computed from the cleared state.
  - Example: SD mode, N=3, sclr & count_cycle gives P=1 next cycle.
- hd_sdn switching 1→0 starts at P=0. Switching 0→1 mid-sample drops the partial sample: P→0, and X/Y are not advanced.
- If X or Y is at or above the new W or H after a shadow reload (only possible via sclr), the wrap comparison uses ≥, so the counter wraps at the next count_sample.

## Timing
- Reset values: P=X=Y=0 and SW=SH=0 (effective 1×1).
  - With count_cycle=0, outputs are count_sample=0, start_of_sample=1, sample_ticks=0, pixel_x=0, line_y=0, end_of_line=0, end_of_frame=0.
- Latency: count_sample, end_of_line and end_of_frame appear in the same cycle as the qualifying count_cycle. Counters show the new position one cycle later.
- Throughput: one count_cycle per clock, with no back-pressure.
- Asserting rst mid-frame clears all state immediately; counting resumes from (0,0) on the first edge after deassertion.
- Wrap-around on the last sample of the frame: X, Y and P all return to 0 together. The new SW and SH take effect from the next cycle.

## Structure
- No shared package types are needed. The effective-size clamp rule (0→1) is a localparam-free function in the block itself.
- One natural sub-module, alt_vipcti131_common_wrap_counter: a parametric width counter with a terminal-value input (wrap on ≥), enable and sync clear.
  - Instantiated three times: plane, x and y.
  - The y instance is enabled by the x wrap.
- Shadow registers and output decode live in the top level.

## Test plan
- SD, N=3, W=4, H=2, count_cycle held high for 24 cycles:
  - count_sample every 3rd cycle.
  - sample_ticks 0,1,2 repeating.
  - end_of_line at cycles 12 and 24.
  - end_of_frame only at cycle 24.
  - All counters 0 afterwards.
- HD mode, W=3, H=3, count_cycle high for 9 cycles: count_sample every cycle, sample_ticks=0, end_of_frame on cycle 9, start_of_sample constantly 1.
- Change active_width 4→2 mid-frame:
  - The current frame still ends after 4×H samples.
  - The next frame's end_of_line comes every 2 samples.
- sclr together with count_cycle in SD mode (N=3) at X=2, Y=1: next cycle P=1, X=0, Y=0, and the shadows equal the inputs.
- active_width=0, active_height=0: every count_sample asserts end_of_line and end_of_frame, and pixel_x and line_y stay 0.
- Assert rst mid-line at X=5, Y=3, P=2: all outputs return to their reset values before the next edge. Toggle hd_sdn 0→1 at P=1: the partial sample is dropped, X is unchanged, and P=0.
